// File: rtl/puf_response_engine.sv
// Sequencer for the dual-adder/PDL arbiter PUF: races each response bit VOTES times,
// resolves it by majority vote and counts bits whose votes were not unanimous.
module puf_response_engine #(
  parameter int unsigned OP_W          = 32,
  parameter int unsigned CFG_W         = 125,
  parameter int unsigned RESP_BITS     = 32,
  parameter int unsigned VOTES         = 5,
  parameter int unsigned PRE_CYCLES    = 2,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               abort,
  input  logic [OP_W-1:0]                    chal_a,
  input  logic [OP_W-1:0]                    chal_b,
  input  logic [CFG_W-1:0]                   cfg1_in,
  input  logic [CFG_W-1:0]                   cfg2_in,
  input  logic                               arb_in,
  output logic [OP_W-1:0]                    op_a,
  output logic [OP_W-1:0]                    op_b,
  output logic [CFG_W-1:0]                   cfg1,
  output logic [CFG_W-1:0]                   cfg2,
  output logic                               busy,
  output logic [RESP_BITS-1:0]               resp,
  output logic                               resp_valid,
  output logic [$clog2(RESP_BITS+1)-1:0]     unstable_cnt
);

  localparam int unsigned CntMax = (PRE_CYCLES > SETTLE_CYCLES) ? PRE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned VoteW  = $clog2(VOTES + 1);
  localparam int unsigned BitW   = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int unsigned UnstW  = $clog2(RESP_BITS + 1);

  typedef enum logic [1:0] {StIdle, StPre, StLaunch, StDecide} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [VoteW-1:0]     vote_q, vote_d;
  logic [VoteW-1:0]     ones_q, ones_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [OP_W-1:0]      chal_a_q, chal_a_d, chal_b_q, chal_b_d;
  logic [OP_W-1:0]      op_a_q, op_a_d, op_b_q, op_b_d;
  logic [CFG_W-1:0]     cfg1_q, cfg1_d, cfg2_q, cfg2_d;
  logic                 busy_q, busy_d, valid_q, valid_d;
  logic [RESP_BITS-1:0] resp_q, resp_d;
  logic [UnstW-1:0]     unst_q, unst_d;

  // Rotate left modulo OP_W so bit indices beyond the operand width wrap around.
  function automatic logic [OP_W-1:0] rotl(input logic [OP_W-1:0] v, input int unsigned amt);
    logic [2*OP_W-1:0] dbl;
    dbl = {v, v} << (amt % OP_W);
    return dbl[2*OP_W-1:OP_W];
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    vote_d   = vote_q;
    ones_d   = ones_q;
    bit_d    = bit_q;
    chal_a_d = chal_a_q;
    chal_b_d = chal_b_q;
    cfg1_d   = cfg1_q;
    cfg2_d   = cfg2_q;
    busy_d   = busy_q;
    valid_d  = valid_q;
    resp_d   = resp_q;
    unst_d   = unst_q;
    op_a_d   = '0;
    op_b_d   = '0;

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          chal_a_d = chal_a;
          chal_b_d = chal_b;
          cfg1_d   = cfg1_in;
          cfg2_d   = cfg2_in;
          resp_d   = '0;
          unst_d   = '0;
          valid_d  = 1'b0;
          busy_d   = 1'b1;
          cnt_d    = '0;
          vote_d   = '0;
          ones_d   = '0;
          bit_d    = '0;
          state_d  = StPre;
        end
      end
      StPre: begin
        if (32'(cnt_q) == PRE_CYCLES - 1) begin
          cnt_d   = '0;
          op_a_d  = rotl(chal_a_q, 32'(bit_q));
          op_b_d  = chal_b_q;
          state_d = StLaunch;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StLaunch: begin
        if (32'(cnt_q) == SETTLE_CYCLES - 1) begin
          // Last settle cycle: the race has resolved, take the arbiter's verdict.
          cnt_d  = '0;
          ones_d = ones_q + VoteW'(arb_in);
          if (32'(vote_q) == VOTES - 1) begin
            state_d = StDecide;
          end else begin
            vote_d  = vote_q + VoteW'(1);
            state_d = StPre;
          end
        end else begin
          cnt_d  = cnt_q + CntW'(1);
          op_a_d = op_a_q;
          op_b_d = op_b_q;
        end
      end
      StDecide: begin
        resp_d[bit_q] = 32'(ones_q) > VOTES / 2;
        if (ones_q != '0 && 32'(ones_q) != VOTES) begin
          unst_d = unst_q + UnstW'(1);
        end
        ones_d = '0;
        vote_d = '0;
        if (32'(bit_q) == RESP_BITS - 1) begin
          busy_d  = 1'b0;
          valid_d = 1'b1;
          state_d = StIdle;
        end else begin
          bit_d   = bit_q + BitW'(1);
          state_d = StPre;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort leaves the partial response in place; resp_valid stays low.
    if (abort && busy_q) begin
      state_d = StIdle;
      busy_d  = 1'b0;
      valid_d = 1'b0;
      op_a_d  = '0;
      op_b_d  = '0;
      resp_d  = resp_q;
      unst_d  = unst_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      vote_q   <= '0;
      ones_q   <= '0;
      bit_q    <= '0;
      chal_a_q <= '0;
      chal_b_q <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      cfg1_q   <= '0;
      cfg2_q   <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      resp_q   <= '0;
      unst_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      vote_q   <= vote_d;
      ones_q   <= ones_d;
      bit_q    <= bit_d;
      chal_a_q <= chal_a_d;
      chal_b_q <= chal_b_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      cfg1_q   <= cfg1_d;
      cfg2_q   <= cfg2_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      resp_q   <= resp_d;
      unst_q   <= unst_d;
    end
  end

  assign op_a         = op_a_q;
  assign op_b         = op_b_q;
  assign cfg1         = cfg1_q;
  assign cfg2         = cfg2_q;
  assign busy         = busy_q;
  assign resp         = resp_q;
  assign resp_valid   = valid_q;
  assign unstable_cnt = unst_q;

endmodule

// File: tb/tb_puf_response_engine.sv
// Directed bench for puf_response_engine at default parameters: schedule-driven arbiter
// stimulus with hand-derived responses, latency and operand sequence expectations.
module tb_puf_response_engine;

  localparam int CFG_W = 125;
  localparam int RB    = 32;
  localparam int V     = 5;
  localparam int P     = 2;
  localparam int S     = 4;
  localparam int PER   = V * (P + S) + 1;  // 31 cycles per bit
  localparam int LAT   = RB * PER;         // 992
  localparam logic [CFG_W-1:0] C1 = {61'h0ABC_DEF0_1234_567, 64'h0123_4567_89AB_CDEF};
  localparam logic [CFG_W-1:0] C2 = {61'h0F0F_0F0F_0F0F_0F0, 64'hFEDC_BA98_7654_3210};

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             arb_in = 1'b0;
  logic [31:0]      chal_a = '0;
  logic [31:0]      chal_b = '0;
  logic [CFG_W-1:0] cfg1_in = '0;
  logic [CFG_W-1:0] cfg2_in = '0;
  logic [31:0]      op_a, op_b, resp;
  logic [CFG_W-1:0] cfg1, cfg2;
  logic             busy, resp_valid;
  logic [5:0]       unstable_cnt;

  int errors = 0;
  int checks = 0;
  int op_bad, busy_bad, cfg_bad, valid_at;

  puf_response_engine dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .chal_a       (chal_a),
    .chal_b       (chal_b),
    .cfg1_in      (cfg1_in),
    .cfg2_in      (cfg2_in),
    .arb_in       (arb_in),
    .op_a         (op_a),
    .op_b         (op_b),
    .cfg1         (cfg1),
    .cfg2         (cfg2),
    .busy         (busy),
    .resp         (resp),
    .resp_valid   (resp_valid),
    .unstable_cnt (unstable_cnt)
  );

  always #5 clk = ~clk;

  // Arbiter outcome for (bit, vote) under each stimulus mode.
  function automatic logic arb_of(input int mode, input int b, input int v);
    logic [4:0] pa;
    logic [4:0] pb;
    pa = 5'b01011;  // votes 0..4 = 1,1,0,1,0
    pb = 5'b00100;  // votes 0..4 = 0,0,1,0,0
    case (mode)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return (b == 3) ? pa[v] : 1'b0;
      default: return (b == 3) ? pb[v] : 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] rotl_ref(input logic [31:0] x, input int b);
    int s;
    s = b % 32;
    if (s == 0) return x;
    return (x << s) | (x >> (32 - s));
  endfunction

  // Runs one accept plus LAT+2 cycles; tallies deviations from the expected schedule.
  task automatic run_seq(input int mode, input logic [31:0] ca, input logic [31:0] cb,
                         input int abort_at, input int restart_at);
    int m, r, b, p, v;
    logic exp_run;
    logic [31:0] eo_a, eo_b;
    op_bad = 0; busy_bad = 0; cfg_bad = 0; valid_at = 0;
    @(negedge clk);
    start = 1'b1; abort = 1'b0; arb_in = 1'b0;
    chal_a = ca; chal_b = cb; cfg1_in = C1; cfg2_in = C2;
    @(posedge clk);
    for (int n = 1; n <= LAT + 2; n++) begin
      @(negedge clk);
      m = n - 1;
      exp_run = ((abort_at == 0) || (m < abort_at)) && (m < LAT);
      eo_a = '0; eo_b = '0;
      if (exp_run && m >= 1) begin
        r = (m - 1) % PER; b = (m - 1) / PER; p = r % (P + S);
        if (r < PER - 1 && p >= P - 1 && p < P + S - 1) begin
          eo_a = rotl_ref(ca, b); eo_b = cb;
        end
      end
      if (op_a !== eo_a || op_b !== eo_b) op_bad++;
      if (busy !== exp_run) busy_bad++;
      if (cfg1 !== C1 || cfg2 !== C2) cfg_bad++;
      if (resp_valid === 1'b1 && valid_at == 0) valid_at = m;
      start = (n == restart_at);
      abort = (n == abort_at);
      chal_a = 32'hDEAD_BEEF; chal_b = ~cb; cfg1_in = ~C1; cfg2_in = ~C2;
      r = (n - 1) % PER; b = (n - 1) / PER;
      v = (r < PER - 1) ? r / (P + S) : 0;
      arb_in = arb_of(mode, b, v);
    end
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got busy=%b valid=%b want 0 0", busy, resp_valid);
    end
    checks++; if (op_a !== 32'h0 || op_b !== 32'h0) begin
      errors++; $display("FAIL reset_ops: got %h %h want 0 0", op_a, op_b);
    end
    checks++; if (resp !== 32'h0 || unstable_cnt !== 6'd0 || cfg1 !== '0 || cfg2 !== '0) begin
      errors++; $display("FAIL reset_data: got resp=%h unst=%0d want 0 0", resp, unstable_cnt);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_all_ones();
    run_seq(0, 32'h1, 32'h0, 0, 0);
    checks++; if (op_bad != 0) begin
      errors++; $display("FAIL ones_opseq: got %0d bad cycles want 0", op_bad);
    end
    checks++; if (busy_bad != 0 || cfg_bad != 0) begin
      errors++; $display("FAIL ones_busycfg: got %0d/%0d bad want 0/0", busy_bad, cfg_bad);
    end
    checks++; if (valid_at != LAT) begin
      errors++; $display("FAIL ones_latency: got %0d want %0d", valid_at, LAT);
    end
    checks++; if (resp !== 32'hFFFF_FFFF || unstable_cnt !== 6'd0) begin
      errors++; $display("FAIL ones_resp: got %h/%0d want ffffffff/0", resp, unstable_cnt);
    end
  endtask

  task automatic test_idle_controls();
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    checks++; if (busy !== 1'b0 || resp_valid !== 1'b1 || resp !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL idle_start_abort: got busy=%b valid=%b resp=%h want 0 1 ffffffff",
                         busy, resp_valid, resp);
    end
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    checks++; if (resp_valid !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_abort: got valid=%b busy=%b want 1 0", resp_valid, busy);
    end
  endtask

  task automatic test_all_zeros();
    run_seq(1, 32'h8000_0001, 32'hA5A5_0F0F, 0, 0);
    checks++; if (op_bad != 0 || busy_bad != 0) begin
      errors++; $display("FAIL zeros_opseq: got %0d/%0d bad want 0/0", op_bad, busy_bad);
    end
    checks++; if (valid_at != LAT) begin
      errors++; $display("FAIL zeros_latency: got %0d want %0d", valid_at, LAT);
    end
    checks++; if (resp !== 32'h0 || unstable_cnt !== 6'd0) begin
      errors++; $display("FAIL zeros_resp: got %h/%0d want 0/0", resp, unstable_cnt);
    end
  endtask

  task automatic test_unstable_bit3();
    run_seq(2, 32'h1, 32'h0, 0, 0);
    checks++; if (resp !== 32'h8 || unstable_cnt !== 6'd1) begin
      errors++; $display("FAIL unstable_major1: got %h/%0d want 8/1", resp, unstable_cnt);
    end
    run_seq(3, 32'h1, 32'h0, 0, 0);
    checks++; if (resp !== 32'h0 || unstable_cnt !== 6'd1) begin
      errors++; $display("FAIL unstable_major0: got %h/%0d want 0/1", resp, unstable_cnt);
    end
  endtask

  task automatic test_restart_ignored();
    run_seq(0, 32'h1, 32'h0, 0, 200);
    checks++; if (op_bad != 0 || cfg_bad != 0) begin
      errors++; $display("FAIL restart_opcfg: got %0d/%0d bad want 0/0", op_bad, cfg_bad);
    end
    checks++; if (valid_at != LAT || resp !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL restart_resp: got %0d/%h want %0d/ffffffff", valid_at, resp, LAT);
    end
  endtask

  task automatic test_abort();
    run_seq(0, 32'h1, 32'h0, 100, 0);
    checks++; if (op_bad != 0 || busy_bad != 0) begin
      errors++; $display("FAIL abort_idle: got %0d/%0d bad want 0/0", op_bad, busy_bad);
    end
    checks++; if (valid_at != 0) begin
      errors++; $display("FAIL abort_valid: got rise at %0d want none", valid_at);
    end
    checks++; if (resp !== 32'h7 || unstable_cnt !== 6'd0) begin
      errors++; $display("FAIL abort_partial: got %h/%0d want 7/0", resp, unstable_cnt);
    end
    run_seq(1, 32'h1, 32'h0, 0, 0);
    checks++; if (valid_at != LAT || resp !== 32'h0) begin
      errors++; $display("FAIL abort_rerun: got %0d/%h want %0d/0", valid_at, resp, LAT);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    start = 1'b1; chal_a = 32'h1; chal_b = 32'h0; cfg1_in = C1; cfg2_in = C2;
    @(posedge clk);
    @(negedge clk); start = 1'b0; arb_in = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    checks++; if (op_a !== 32'h1 || busy !== 1'b1) begin
      errors++; $display("FAIL arst_launch: got op_a=%h busy=%b want 1 1", op_a, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++; if (op_a !== 32'h0 || busy !== 1'b0 || cfg1 !== '0 || cfg2 !== '0 ||
                  resp !== 32'h0 || resp_valid !== 1'b0 || unstable_cnt !== 6'd0) begin
      errors++; $display("FAIL arst_clear: got op_a=%h busy=%b valid=%b want 0 0 0",
                         op_a, busy, resp_valid);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_seq(0, 32'h1, 32'h0, 0, 0);
    checks++; if (valid_at != LAT || resp !== 32'hFFFF_FFFF || op_bad != 0) begin
      errors++; $display("FAIL arst_rerun: got %0d/%h/%0d want %0d/ffffffff/0",
                         valid_at, resp, op_bad, LAT);
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_idle_controls();
    test_all_zeros();
    test_unstable_bit3();
    test_restart_ignored();
    test_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
